red_iterativa_der_izq: RTL and testbench

- Right-to-left (LSB→MSB) iterative magnitude comparator over K-bit words A and B.
  - A chain of K identical cells propagates a "greater-so-far" signal from bit 0 to bit K-1.
  - The final cell's output is Z = (A > B).
- Parallel result: the full cell chain N and Z are registered once per clock.
- Serial trace engine: on request, replays the operand bits and chain bits one bit per clock, LSB first, for waveform inspection.
- Sits downstream of the stimulus generator `tester`, which drives A and B.

---
 rtl/red_iterativa_der_izq.sv | 160 ++++++++++++++++
 tb/tb_red_iterativa_der_izq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/red_iterativa_der_izq.sv
// -----------------------------------------------------------------------------
// red_iterativa_der_izq
//
// Right-to-left (LSB to MSB) iterative magnitude comparator over K-bit words.
// A chain of K identical cells propagates a "greater-so-far" bit from bit 0
// up to bit K-1; the last cell yields Z = (A > B).
//
// Two independent views of the chain:
//   * Parallel path: the whole chain N and Z are registered every clock.
//   * Serial trace engine: on start, captures A/B/chain and replays them one
//     bit per clock, LSB first, for waveform inspection.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   A, B   in   K-bit unsigned operands
//   start  in   request a serial trace of the current A/B (ignored while busy)
//   N      out  registered chain, N[i] = 1 iff A[i:0] > B[i:0]
//   Z      out  registered comparison result (= N[K-1])
//   busy   out  high while a trace is running
//   idx    out  bit index presented on the trace outputs
//   A_t    out  captured A bit at idx
//   B_t    out  captured B bit at idx
//   N_t    out  captured chain bit at idx
//   done   out  one-cycle pulse on the last trace step
// -----------------------------------------------------------------------------
module red_iterativa_der_izq #(
    parameter int unsigned K = 4,
    localparam int unsigned IW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [K-1:0]  A,
    input  logic [K-1:0]  B,
    input  logic          start,
    output logic [K-1:0]  N,
    output logic          Z,
    output logic          busy,
    output logic [IW-1:0] idx,
    output logic          A_t,
    output logic          B_t,
    output logic          N_t,
    output logic          done
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [IW-1:0] LastIdx = IW'(K - 1);

    // Cell chain
    logic [K-1:0] c;

    always_comb begin
        logic carry;
        carry = 1'b0;
        c     = '0;
        for (int unsigned i = 0; i < K; i++) begin
            // Strictly greater at this bit, or equal here and greater below.
            carry = (A[i] & ~B[i]) | (~(A[i] ^ B[i]) & carry);
            c[i]  = carry;
        end
    end

    // State
    state_e        state_q, state_d;
    logic [K-1:0]  n_q, n_d;
    logic          z_q, z_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          a_t_q, a_t_d;
    logic          b_t_q, b_t_d;
    logic          n_t_q, n_t_d;
    logic          done_q, done_d;
    logic [K-1:0]  acap_q, acap_d;
    logic [K-1:0]  bcap_q, bcap_d;
    logic [K-1:0]  ncap_q, ncap_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_t_d   = a_t_q;
        b_t_d   = b_t_q;
        n_t_d   = n_t_q;
        acap_d  = acap_q;
        bcap_d  = bcap_q;
        ncap_d  = ncap_q;
        done_d  = 1'b0;

        // Parallel path tracks live operands unconditionally.
        n_d = c;
        z_d = c[K-1];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acap_d  = A;
                    bcap_d  = B;
                    ncap_d  = c;
                    idx_d   = '0;
                    // Trace outputs are registered, so bit 0 is loaded
                    // straight from the live operands on the capture edge.
                    a_t_d   = A[0];
                    b_t_d   = B[0];
                    n_t_d   = c[0];
                    state_d = StRun;
                end
            end
            StRun: begin
                if (idx_q != LastIdx) begin
                    idx_d  = idx_q + IW'(1);
                    a_t_d  = acap_q[idx_d];
                    b_t_d  = bcap_q[idx_d];
                    n_t_d  = ncap_q[idx_d];
                    // done is registered: raise it together with the last index.
                    done_d = (idx_d == LastIdx);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            z_q     <= 1'b0;
            idx_q   <= '0;
            a_t_q   <= 1'b0;
            b_t_q   <= 1'b0;
            n_t_q   <= 1'b0;
            done_q  <= 1'b0;
            acap_q  <= '0;
            bcap_q  <= '0;
            ncap_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
            a_t_q   <= a_t_d;
            b_t_q   <= b_t_d;
            n_t_q   <= n_t_d;
            done_q  <= done_d;
            acap_q  <= acap_d;
            bcap_q  <= bcap_d;
            ncap_q  <= ncap_d;
        end
    end

    assign N    = n_q;
    assign Z    = z_q;
    assign busy = (state_q == StRun);
    assign idx  = idx_q;
    assign A_t  = a_t_q;
    assign B_t  = b_t_q;
    assign N_t  = n_t_q;
    assign done = done_q;

endmodule

// File: tb/tb_red_iterativa_der_izq.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for red_iterativa_der_izq (K = 4).
// Stimulus pushes expected parallel results and trace steps, tagged with the
// cycle in which they must appear; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_red_iterativa_der_izq;

    localparam int unsigned K = 4;

    typedef struct {
        int         cyc;
        logic [3:0] n;
        logic       z;
    } par_t;

    typedef struct {
        int         cyc;
        logic       busy;
        logic [1:0] idx;
        logic       a;
        logic       b;
        logic       n;
        logic       done;
    } trace_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       start = 1'b0;
    logic [3:0] n;
    logic       z;
    logic       busy;
    logic [1:0] idx;
    logic       a_t;
    logic       b_t;
    logic       n_t;
    logic       done;

    red_iterativa_der_izq #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .start (start),
        .N     (n),
        .Z     (z),
        .busy  (busy),
        .idx   (idx),
        .A_t   (a_t),
        .B_t   (b_t),
        .N_t   (n_t),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    par_t   pq[$];
    trace_t tq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: prefix comparison on masked operands.
    function automatic logic [3:0] ref_n(input logic [3:0] av, input logic [3:0] bv);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int mask;
            mask = (1 << (i + 1)) - 1;
            r[i] = ((int'(av) & mask) > (int'(bv) & mask));
        end
        return r;
    endfunction

    // Drive one cycle of inputs; expect N/Z one edge later.
    task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic st,
                        input logic [3:0] en, input logic ez);
        par_t e;
        a     = av;
        b     = bv;
        start = st;
        e.cyc = cyc + 1;
        e.n   = en;
        e.z   = ez;
        pq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Expected trace for a start edge leaving cycle c0; vectors are LSB = idx 0.
    task automatic push_trace(input logic [3:0] at, input logic [3:0] bt, input logic [3:0] nt,
                              input int c0, input int steps);
        trace_t t;
        for (int j = 0; j < steps; j++) begin
            t.cyc  = c0 + 1 + j;
            t.busy = 1'b1;
            t.idx  = 2'(j);
            t.a    = at[j];
            t.b    = bt[j];
            t.n    = nt[j];
            t.done = (j == K - 1);
            tq.push_back(t);
        end
        if (steps == K) begin
            t.cyc  = c0 + 1 + K;
            t.busy = 1'b0;
            t.idx  = '0;
            t.a    = 1'b0;
            t.b    = 1'b0;
            t.n    = 1'b0;
            t.done = 1'b0;
            tq.push_back(t);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        par_t   pe;
        trace_t te;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            pe = pq.pop_front();
            check("par_N", 32'(n), 32'(pe.n));
            check("par_Z", 32'(z), 32'(pe.z));
        end
        if (tq.size() > 0 && tq[0].cyc == cyc) begin
            te = tq.pop_front();
            check("trace_busy", 32'(busy), 32'(te.busy));
            if (te.busy) begin
                check("trace_idx", 32'(idx), 32'(te.idx));
                check("trace_A_t", 32'(a_t), 32'(te.a));
                check("trace_B_t", 32'(b_t), 32'(te.b));
                check("trace_N_t", 32'(n_t), 32'(te.n));
                check("trace_done", 32'(done), 32'(te.done));
            end else begin
                check("trace_end_done", 32'(done), 32'(0));
            end
        end else begin
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_done", 32'(done), 32'(0));
        end
    end

    int c0;

    initial begin
        // Reset with live operands applied
        a = 4'b1010;
        b = 4'b0110;
        repeat (3) @(posedge clk);
        #2;
        check("rst_N", 32'(n), 32'(0));
        check("rst_Z", 32'(z), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_idx", 32'(idx), 32'(0));
        check("rst_trace_bits", 32'({a_t, b_t, n_t}), 32'(0));
        rst_n = 1'b1;

        // Parallel directed vectors
        step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);
        step(4'b0011, 4'b0101, 1'b0, 4'b0010, 1'b0);
        step(4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 4'b1111, 1'b1);
        step(4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0);

        // Basic serial trace
        c0 = cyc;
        push_trace(4'b1010, 4'b0110, 4'b1000, c0, K);
        step(4'b1010, 4'b0110, 1'b1, 4'b1000, 1'b1);
        repeat (K + 1) step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);

        // Capture isolation: operands drop to zero right after the start edge
        c0 = cyc;
        push_trace(4'b1111, 4'b0000, 4'b1111, c0, K);
        step(4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        repeat (K) step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // start held high: second trace only after one idle cycle, using the
        // operands present when it is finally accepted
        c0 = cyc;
        push_trace(4'b0011, 4'b0101, 4'b0010, c0, K);
        push_trace(4'b1010, 4'b0110, 4'b1000, c0 + K + 1, K);
        step(4'b0011, 4'b0101, 1'b1, 4'b0010, 1'b0);
        repeat (K + 1) step(4'b1010, 4'b0110, 1'b1, 4'b1000, 1'b1);
        repeat (K + 1) step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);

        // Reset mid-trace at idx = 2
        c0 = cyc;
        push_trace(4'b1010, 4'b0110, 4'b1000, c0, 3);
        step(4'b1010, 4'b0110, 1'b1, 4'b1000, 1'b1);
        step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);
        step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_idx", 32'(idx), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_trace_bits", 32'({a_t, b_t, n_t}), 32'(0));
        check("midrst_N", 32'(n), 32'(0));
        @(posedge clk);
        #2;
        check("midrst_hold_N", 32'(n), 32'(0));
        check("midrst_hold_Z", 32'(z), 32'(0));
        check("midrst_hold_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        repeat (K + 1) step(4'b1010, 4'b0110, 1'b0, 4'b1000, 1'b1);

        // Exhaustive parallel sweep
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                step(4'(ai), 4'(bi), 1'b0, ref_n(4'(ai), 4'(bi)), (ai > bi));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("par_queue_drained", 32'(pq.size()), 32'(0));
        check("trace_queue_drained", 32'(tq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
